axis_block_framer: RTL and testbench
====================================

Name: axis_block_framer

Overview:
- Successor to the fixed power-of-two TLAST generator in the DMA/SD-adapter stream path.
- Frames an AXI4-Stream into blocks of a runtime-programmable length (any value 1..2^LEN_WIDTH-1); upstream TLAST from the CPU path still ends a block early.
- Adds an optional restart-on-upstream-TLAST mode, an optional registered output slice for timing closure, and packet/short-block status.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- LEN_WIDTH, 16, width of block length and beat counter; max block = 2^LEN_WIDTH-1 beats.
- REGISTERED, 1: 1 = 2-entry skid buffer on the output; 0 = combinational pass-through.
- CNT_WIDTH, 32, width of the packet counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  upstream data.
- s_axis_tlast  in  1  upstream end-of-block from the CPU path.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- m_axis_tdata  out  DATA_WIDTH  downstream data.
- m_axis_tlast  out  1  downstream end-of-block.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- cfg_block_len  in  LEN_WIDTH  beats per block; 0 = no generated TLAST, upstream TLAST only.
- cfg_restart_on_tlast  in  1  1 = upstream TLAST resets the beat counter.
- stat_pkt_count  out  CNT_WIDTH  number of TLAST beats accepted downstream; wraps.
- stat_short_pkt  out  1  one-cycle pulse when a block is ended by upstream TLAST before reaching its length.
- stat_in_block  out  1  high while beat counter != 0.

Behaviour:
- Definitions:
  - s_fire = s_axis_tvalid & s_axis_tready
  - m_fire = m_axis_tvalid & m_axis_tready
- Length latch: len_q loads cfg_block_len on s_fire when count == 0.
  - eff_len = (count == 0) ? cfg_block_len : len_q.
  - cfg changes mid-block are ignored until the next block starts.
- Generated TLAST: gen_last = (eff_len != 0) & (count == eff_len - 1). eff_len = 1 marks every beat. Compare at LEN_WIDTH bits with no overflow.
- Tagged TLAST: tag_last = s_axis_tlast | gen_last, evaluated on the input side and carried with the data.
- Counter update on s_fire:
  - gen_last → count <= 0.
  - s_axis_tlast & cfg_restart_on_tlast → count <= 0.
  - otherwise count <= count + 1.
  - With restart = 0, upstream TLAST does not disturb the counter (legacy fixed-grid behaviour).
  - With eff_len = 0, count wraps modulo 2^LEN_WIDTH.
- stat_short_pkt: pulses the cycle after s_fire with s_axis_tlast & !gen_last & cfg_restart_on_tlast & eff_len != 0.
- stat_pkt_count increments on m_fire & m_axis_tlast.
- REGISTERED = 0:
  - m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, m_axis_tlast = tag_last.
  - s_axis_tready = m_axis_tready & aresetn.
  - Latency 0.
- REGISTERED = 1:
  - 2-entry skid buffer, all outputs registered.
  - s_axis_tready = !full, registered.
  - Latency 1 cycle from s_fire to m_axis_tvalid.
  - Sustains 1 beat/cycle with m_axis_tready held high.
  - m_axis_* stable while m_axis_tvalid & !m_axis_tready.
  - Entries are FIFO-ordered; simultaneous push and pop on 1 entry keeps occupancy at 1.
- Reset (asynchronous, any time including mid-block):
  - count, len_q, stat_pkt_count = 0; stat_short_pkt = 0.
  - Skid buffer emptied: m_axis_tvalid = 0; buffered beats are discarded.
  - s_axis_tready = 0 while aresetn is low.
  - After release, the first beat starts a new block.

Decomposition:
- No shared package; LEN_WIDTH and CNT_WIDTH stay module parameters.
- One sub-module: axis_skid_buffer (parameter WIDTH = DATA_WIDTH+1, carries {tlast, tdata}).
  - Instantiated only when REGISTERED = 1, via a generate branch.
  - Reusable elsewhere in the adapter.

Test Plan:
- len = 5, restart = 0, 12 beats, m_ready = 1 → TLAST on beats 4 and 9; stat_pkt_count = 2; REGISTERED = 1 gives 1-cycle latency and no bubbles.
- len = 512, restart = 1, upstream TLAST on beat 99 → TLAST on beat 99; stat_short_pkt pulses once; next block TLAST 512 beats later; pkt_count = 2.
- len = 3, restart = 0, upstream TLAST on beat 1 → TLAST on beats 1 and 2; no short pulse; count continues.
- cfg_block_len changed 4 → 2 at beat 1 → current block still ends at beat 3; following blocks end every 2nd beat; len = 1 marks every beat; len = 0 gives upstream TLAST only.
- Random m_ready (30% high), len = 7, 200 beats → data order and TLAST positions match the model; m outputs stable while stalled; no beat lost or duplicated.
- aresetn asserted mid-block with the buffer full → same edge: m_valid = 0, s_ready = 0; after release, a 5-beat run with len = 5 gives TLAST on beat 4 and pkt_count = 1.

Source files
------------

// File: rtl/axis_block_framer_if.sv
// ---------------------------------------------------------------------------
// axis_block_framer_if
//   Generic valid/ready stream bundle used between the framer core and its
//   output skid buffer (and by anything else in the adapter that wants a
//   plain payload/valid/ready channel).
//
//   payload  WIDTH  stream payload (the framer packs {tlast, tdata})
//   valid    1      payload valid
//   ready    1      consumer ready
//
//   modport master : drives payload/valid, observes ready
//   modport slave  : observes payload/valid, drives ready
// ---------------------------------------------------------------------------
interface axis_block_framer_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] payload;
  logic             valid;
  logic             ready;

  modport master (output payload, output valid, input ready);
  modport slave  (input payload, input valid, output ready);
endinterface

// File: rtl/axis_block_framer_skid.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
//   Two-entry FIFO-ordered skid buffer with fully registered outputs.
//   Upstream ready is a flop (high while not full), downstream payload/valid
//   come straight from the head register, so the slice breaks every
//   combinational path through it while still sustaining one beat per cycle.
//
//   aclk     in   clock, rising edge
//   aresetn  in   asynchronous active-low reset; empties the buffer
//   s_if     slave   upstream channel  (payload/valid in, ready out)
//   m_if     master  downstream channel (payload/valid out, ready in)
// ---------------------------------------------------------------------------
module axis_skid_buffer #(
  parameter int WIDTH = 9
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_block_framer_if.slave    s_if,
  axis_block_framer_if.master   m_if
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             push;
  logic             pop;

  assign m_if.payload = head_q;
  assign m_if.valid   = valid_q;
  assign s_if.ready   = ready_q;

  // Next-state for the two entries and occupancy; head is always the oldest.
  always_comb begin
    push    = s_if.valid & ready_q;
    pop     = valid_q & m_if.ready;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = s_if.payload;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // Streaming case: the new beat replaces the departing head.
          head_d = s_if.payload;
          occ_d  = 2'd1;
        end else if (push) begin
          tail_d = s_if.payload;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end else begin
          occ_d  = 2'd1;
        end
      end
      2'd2: begin
        // Full: ready is low, so only a pop can happen.
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd2;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
    valid_d = (occ_d != 2'd0);
    ready_d = (occ_d != 2'd2);
  end

  // Buffer state registers; reset discards any buffered beats.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/axis_block_framer.sv
// ---------------------------------------------------------------------------
// axis_block_framer
//   Splits an AXI4-Stream into blocks of a runtime-programmable length by
//   generating TLAST; upstream TLAST still ends a block early. Optionally
//   restarts the beat grid on upstream TLAST, optionally registers the output
//   through a 2-entry skid buffer, and reports packet/short-block status.
//
//   aclk, aresetn            clock / asynchronous active-low reset
//   s_axis_*                 upstream stream (tdata, tlast, tvalid, tready)
//   m_axis_*                 downstream stream (tdata, tlast, tvalid, tready)
//   cfg_block_len            beats per block, 0 = upstream TLAST only
//   cfg_restart_on_tlast     upstream TLAST restarts the beat counter
//   stat_pkt_count           TLAST beats accepted downstream (wraps)
//   stat_short_pkt           pulse: block ended early by upstream TLAST
//   stat_in_block            beat counter is non-zero
// ---------------------------------------------------------------------------
module axis_block_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int REGISTERED = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [LEN_WIDTH-1:0]  cfg_block_len,
  input  logic                  cfg_restart_on_tlast,
  output logic [CNT_WIDTH-1:0]  stat_pkt_count,
  output logic                  stat_short_pkt,
  output logic                  stat_in_block
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 short_q, short_d;
  logic                 in_block_q, in_block_d;
  logic [LEN_WIDTH-1:0] eff_len;
  logic                 gen_last;
  logic                 tag_last;
  logic                 s_fire;
  logic                 m_fire;

  assign stat_pkt_count = pkt_count_q;
  assign stat_short_pkt = short_q;
  assign stat_in_block  = in_block_q;

  // Block framing: length latch, generated TLAST and beat counter update.
  always_comb begin
    // The first beat of a block sees the live config; later beats the latch.
    eff_len  = (count_q == LEN_ZERO) ? cfg_block_len : len_q;
    // eff_len is non-zero whenever the subtraction matters, so no underflow.
    gen_last = (eff_len != LEN_ZERO) && (count_q == (eff_len - LEN_ONE));
    tag_last = s_axis_tlast | gen_last;
    s_fire   = s_axis_tvalid & s_axis_tready;
    m_fire   = m_axis_tvalid & m_axis_tready;
    count_d  = count_q;
    len_d    = len_q;
    short_d  = 1'b0;
    if (s_fire) begin
      if (count_q == LEN_ZERO) begin
        len_d = cfg_block_len;
      end else begin
        len_d = len_q;
      end
      if (gen_last) begin
        count_d = LEN_ZERO;
      end else if (s_axis_tlast && cfg_restart_on_tlast) begin
        count_d = LEN_ZERO;
      end else begin
        count_d = count_q + LEN_ONE;
      end
      short_d = s_axis_tlast & ~gen_last & cfg_restart_on_tlast &
                (eff_len != LEN_ZERO);
    end else begin
      count_d = count_q;
    end
    in_block_d = (count_d != LEN_ZERO);
    if (m_fire && m_axis_tlast) begin
      pkt_count_d = pkt_count_q + CNT_ONE;
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // Framing state and status registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q     <= LEN_ZERO;
      len_q       <= LEN_ZERO;
      pkt_count_q <= {CNT_WIDTH{1'b0}};
      short_q     <= 1'b0;
      in_block_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      len_q       <= len_d;
      pkt_count_q <= pkt_count_d;
      short_q     <= short_d;
      in_block_q  <= in_block_d;
    end
  end

  generate
    if (REGISTERED != 0) begin : gen_reg
      axis_block_framer_if #(.WIDTH(DATA_WIDTH + 1)) sb_in_if ();
      axis_block_framer_if #(.WIDTH(DATA_WIDTH + 1)) sb_out_if ();

      assign sb_in_if.payload  = {tag_last, s_axis_tdata};
      assign sb_in_if.valid    = s_axis_tvalid;
      assign s_axis_tready     = sb_in_if.ready;
      assign m_axis_tdata      = sb_out_if.payload[DATA_WIDTH-1:0];
      assign m_axis_tlast      = sb_out_if.payload[DATA_WIDTH];
      assign m_axis_tvalid     = sb_out_if.valid;
      assign sb_out_if.ready   = m_axis_tready;

      axis_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_if    (sb_in_if),
        .m_if    (sb_out_if)
      );
    end else begin : gen_pass
      assign m_axis_tdata  = s_axis_tdata;
      assign m_axis_tlast  = tag_last;
      assign m_axis_tvalid = s_axis_tvalid;
      // Gate with reset so upstream never sees ready while held in reset.
      assign s_axis_tready = m_axis_tready & aresetn;
    end
  endgenerate

endmodule

// File: tb/tb_axis_block_framer.sv
// ---------------------------------------------------------------------------
// tb_axis_block_framer
//   Directed + randomized bench for axis_block_framer (REGISTERED = 1).
//   A behavioural model predicts, per accepted input beat, the {tlast, data}
//   that must leave the block, plus the status outputs.
// ---------------------------------------------------------------------------
module tb_axis_block_framer;

  localparam int DW = 8;
  localparam int LW = 16;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_data;
  logic          s_last, s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic          m_last, m_valid, m_ready;
  logic [LW-1:0] cfg_len;
  logic          cfg_restart;
  logic [CW-1:0] stat_pkt;
  logic          stat_short, stat_inb;

  axis_block_framer_if #(.WIDTH(DW + 1)) mon_if ();
  assign mon_if.payload = {m_last, m_data};
  assign mon_if.valid   = m_valid;
  assign mon_if.ready   = m_ready;

  axis_block_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .REGISTERED(1), .CNT_WIDTH(CW)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_tdata         (s_data),
    .s_axis_tlast         (s_last),
    .s_axis_tvalid        (s_valid),
    .s_axis_tready        (s_ready),
    .m_axis_tdata         (m_data),
    .m_axis_tlast         (m_last),
    .m_axis_tvalid        (m_valid),
    .m_axis_tready        (m_ready),
    .cfg_block_len        (cfg_len),
    .cfg_restart_on_tlast (cfg_restart),
    .stat_pkt_count       (stat_pkt),
    .stat_short_pkt       (stat_short),
    .stat_in_block        (stat_inb)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [DW:0] exp_q[$];
  int          last_idx[$];
  int          m_pos, m_len, m_pkt, fires, out_idx, short_cnt;
  bit          short_pend, prev_stall, rnd_ready;
  logic [DW:0] prev_pl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int li(input int k);
    return (k < last_idx.size()) ? last_idx[k] : -1;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    last_idx.delete();
    m_pos = 0; m_len = 0; m_pkt = 0; fires = 0; out_idx = 0; short_cnt = 0;
    short_pend = 1'b0; prev_stall = 1'b0; prev_pl = '0;
  endtask

  // Monitor + reference model, sampled on the falling edge.
  always @(negedge aclk) begin
    logic [DW:0] e;
    bit          gl;
    int          eff;
    if (aresetn === 1'b1) begin
      chk("in_block", stat_inb, (m_pos != 0));
      chk("short_pkt", stat_short, short_pend);
      if (stat_short === 1'b1) short_cnt++;
      chk("pkt_count", stat_pkt, m_pkt);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_payload", mon_if.payload, prev_pl);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL extra_beat: observed %0h with no beat expected", mon_if.payload);
        end else begin
          e = exp_q.pop_front();
          chk("beat", mon_if.payload, e);
          if (e[DW]) m_pkt++;
        end
        if (m_last) last_idx.push_back(out_idx);
        out_idx++;
        fires++;
      end
      if (s_valid && s_ready) begin
        if (m_pos == 0) m_len = int'(cfg_len);
        eff = m_len;
        gl  = (eff != 0) && (m_pos == eff - 1);
        exp_q.push_back({s_last | gl, s_data});
        short_pend = s_last && !gl && cfg_restart && (eff != 0);
        if (gl || (s_last && cfg_restart)) m_pos = 0;
        else m_pos = (m_pos + 1) % 65536;
      end else begin
        short_pend = 1'b0;
      end
      prev_stall = m_valid && !m_ready;
      prev_pl    = mon_if.payload;
    end
  end

  task automatic do_reset();
    s_valid = 1'b0;
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_pkt", stat_pkt, 0);
    chk("rst_short", stat_short, 1'b0);
    chk("rst_in_block", stat_inb, 1'b0);
    clear_model();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit acc;
    acc     = 1'b0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge aclk);
      acc = s_ready;
      @(posedge aclk);
      #1;
      if (rnd_ready) m_ready = ($urandom_range(0, 99) < 30);
      if (acc) break;
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout: s_ready observed %0b required 1", s_ready);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge aclk);
      #1;
      if (rnd_ready) m_ready = ($urandom_range(0, 99) < 30);
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int f0;
    aresetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1; cfg_len = 16'd5; cfg_restart = 1'b0; rnd_ready = 1'b0;
    clear_model();
    #12;
    chk("init_s_ready", s_ready, 1'b0);
    chk("init_m_valid", m_valid, 1'b0);
    chk("init_pkt", stat_pkt, 0);
    chk("init_short", stat_short, 1'b0);
    chk("init_in_block", stat_inb, 1'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // 1: len 5, no restart, 12 back-to-back beats
    chk("t1_idle_valid", m_valid, 1'b0);
    f0 = fires;
    send(8'($urandom), 1'b0);
    chk("t1_latency", m_valid, 1'b1);
    for (int i = 1; i < 12; i++) send(8'($urandom), 1'b0);
    @(posedge aclk); #1;
    chk("t1_no_bubble", fires - f0, 12);
    drain();
    chk("t1_pkt", stat_pkt, 2);
    chk("t1_nlast", last_idx.size(), 2);
    chk("t1_last0", li(0), 4);
    chk("t1_last1", li(1), 9);

    // 2: len 512, restart, upstream TLAST on beat 99
    do_reset();
    cfg_len = 16'd512; cfg_restart = 1'b1;
    for (int i = 0; i < 612; i++) send(8'($urandom), (i == 99));
    drain();
    chk("t2_short_cnt", short_cnt, 1);
    chk("t2_pkt", stat_pkt, 2);
    chk("t2_last0", li(0), 99);
    chk("t2_last1", li(1), 611);

    // 3: len 3, no restart, upstream TLAST on beat 1
    do_reset();
    cfg_len = 16'd3; cfg_restart = 1'b0;
    for (int i = 0; i < 6; i++) send(8'($urandom), (i == 1));
    drain();
    chk("t3_short_cnt", short_cnt, 0);
    chk("t3_nlast", last_idx.size(), 3);
    chk("t3_last0", li(0), 1);
    chk("t3_last1", li(1), 2);
    chk("t3_last2", li(2), 5);

    // 4: mid-block cfg change, then len 1, then len 0
    do_reset();
    cfg_len = 16'd4; cfg_restart = 1'b0;
    send(8'($urandom), 1'b0);
    cfg_len = 16'd2;
    for (int i = 1; i < 8; i++) send(8'($urandom), 1'b0);
    cfg_len = 16'd1;
    for (int i = 8; i < 11; i++) send(8'($urandom), 1'b0);
    cfg_len = 16'd0;
    for (int i = 11; i < 18; i++) send(8'($urandom), (i == 14));
    drain();
    chk("t4_nlast", last_idx.size(), 7);
    chk("t4_last0", li(0), 3);
    chk("t4_last1", li(1), 5);
    chk("t4_last2", li(2), 7);
    chk("t4_last3", li(3), 8);
    chk("t4_last5", li(5), 10);
    chk("t4_last6", li(6), 14);
    chk("t4_pkt", stat_pkt, 7);

    // 5: random backpressure, len 7, random upstream TLAST with restart
    do_reset();
    cfg_len = 16'd7; cfg_restart = 1'b1; rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) send(8'($urandom), ($urandom_range(0, 99) < 8));
    drain();
    rnd_ready = 1'b0; m_ready = 1'b1;
    chk("t5_fires", fires, 200);

    // 6: reset with the buffer full, then a clean 5-beat block
    do_reset();
    cfg_len = 16'd5; cfg_restart = 1'b0; m_ready = 1'b0;
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    chk("t6_full_ready", s_ready, 1'b0);
    chk("t6_full_valid", m_valid, 1'b1);
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
    drain();
    chk("t6_nlast", last_idx.size(), 1);
    chk("t6_last0", li(0), 4);
    chk("t6_pkt", stat_pkt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
